// File: rtl/c17_pipe_bist.sv
// Pipelined, lane-parallel c17 NAND netlist behind a valid/ready stream,
// with a self-test sequencer that sweeps all 32 patterns into a 16-bit MISR.
module c17_pipe_bist #(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LANES-1:0] in_n1,
  input  logic [LANES-1:0] in_n2,
  input  logic [LANES-1:0] in_n3,
  input  logic [LANES-1:0] in_n6,
  input  logic [LANES-1:0] in_n7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LANES-1:0] out_n22,
  output logic [LANES-1:0] out_n23,
  input  logic             bist_start,
  output logic             bist_busy,
  output logic             bist_done,
  output logic [15:0]      bist_sig
);

  // state  | meaning
  // IDLE   | user traffic, self-test never run since reset
  // DRAIN  | input closed, waiting for in-flight user beats to leave
  // RUN    | injecting self-test pattern p = 0..31, one per cycle
  // FLUSH  | waiting for the last self-test beats to reach the MISR
  // DONE   | signature valid and held, user traffic open again
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_RUN   = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic [4:0]  pat_q;
  logic [15:0] sig_q, misr_next, misr_d;

  logic user_mode, run, start_acc, pipe_empty, first_ok;
  logic f_valid, f_tag;
  logic [LANES-1:0] f_n1, f_n2, f_n3, f_n6, f_n7;
  logic [LANES-1:0] p_n1, p_n2, p_n3, p_n6, p_n7;
  logic [LANES-1:0][4:0] lane_q;

  logic             st_valid, st_tag;
  logic [LANES-1:0] st_n10, st_n11, st_n2, st_n7;
  logic [LANES-1:0] n16, n19, n22, n23;

  logic             o_valid_q, o_tag_q;
  logic [LANES-1:0] o_n22_q, o_n23_q;
  logic             out_take, o_load_ok;

  assign user_mode = (state_q == S_IDLE) || (state_q == S_DONE);
  assign run       = (state_q == S_RUN);
  assign start_acc = user_mode && bist_start;

  // Lane i sees pattern (p + i) mod 32, bits map to {N1,N2,N3,N6,N7}.
  for (genvar g = 0; g < LANES; g++) begin : g_pat
    assign lane_q[g] = pat_q + 5'(g);
    assign p_n1[g]   = lane_q[g][4];
    assign p_n2[g]   = lane_q[g][3];
    assign p_n3[g]   = lane_q[g][2];
    assign p_n6[g]   = lane_q[g][1];
    assign p_n7[g]   = lane_q[g][0];
  end

  // Self-test beats drain unconditionally and are never shown to the consumer.
  assign out_take  = o_valid_q && (o_tag_q || out_ready);
  assign o_load_ok = !o_valid_q || out_take;

  assign in_ready = !rst && user_mode && first_ok;
  assign f_valid  = run || (in_valid && in_ready);
  assign f_tag    = run;
  assign f_n1     = run ? p_n1 : in_n1;
  assign f_n2     = run ? p_n2 : in_n2;
  assign f_n3     = run ? p_n3 : in_n3;
  assign f_n6     = run ? p_n6 : in_n6;
  assign f_n7     = run ? p_n7 : in_n7;

  if (PIPE == 2) begin : g_pipe2
    logic             s1_valid_q, s1_tag_q;
    logic [LANES-1:0] s1_n10_q, s1_n11_q, s1_n2_q, s1_n7_q;
    logic             s1_ok;

    assign s1_ok    = !s1_valid_q || o_load_ok;
    assign first_ok = s1_ok;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_tag_q   <= 1'b0;
        s1_n10_q   <= '0;
        s1_n11_q   <= '0;
        s1_n2_q    <= '0;
        s1_n7_q    <= '0;
      end else if (s1_ok) begin
        s1_valid_q <= f_valid;
        s1_tag_q   <= f_tag;
        if (f_valid) begin
          s1_n10_q <= ~(f_n1 & f_n3);
          s1_n11_q <= ~(f_n3 & f_n6);
          s1_n2_q  <= f_n2;
          s1_n7_q  <= f_n7;
        end
      end
    end

    assign st_valid   = s1_valid_q;
    assign st_tag     = s1_tag_q;
    assign st_n10     = s1_n10_q;
    assign st_n11     = s1_n11_q;
    assign st_n2      = s1_n2_q;
    assign st_n7      = s1_n7_q;
    assign pipe_empty = !s1_valid_q && !o_valid_q;
  end else begin : g_pipe1
    assign first_ok   = o_load_ok;
    assign st_valid   = f_valid;
    assign st_tag     = f_tag;
    assign st_n10     = ~(f_n1 & f_n3);
    assign st_n11     = ~(f_n3 & f_n6);
    assign st_n2      = f_n2;
    assign st_n7      = f_n7;
    assign pipe_empty = !o_valid_q;
  end

  assign n16 = ~(st_n2 & st_n11);
  assign n19 = ~(st_n11 & st_n7);
  assign n22 = ~(st_n10 & n16);
  assign n23 = ~(n16 & n19);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_tag_q   <= 1'b0;
      o_n22_q   <= '0;
      o_n23_q   <= '0;
    end else if (o_load_ok) begin
      o_valid_q <= st_valid;
      o_tag_q   <= st_tag;
      if (st_valid) begin
        o_n22_q <= n22;
        o_n23_q <= n23;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (bist_start) state_d = S_DRAIN;
      S_DRAIN:        if (pipe_empty) state_d = S_RUN;
      S_RUN:          if (pat_q == 5'd31) state_d = S_FLUSH;
      S_FLUSH:        if (pipe_empty) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    misr_d = '0;
    misr_d[2*LANES-1:0] = {o_n23_q, o_n22_q};
    misr_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? 16'h1021 : 16'h0000) ^ misr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= run ? pat_q + 5'd1 : 5'd0;
      if (start_acc)
        sig_q <= '0;
      else if (o_valid_q && o_tag_q)
        sig_q <= misr_next;
    end
  end

  assign out_valid = o_valid_q && !o_tag_q;
  assign out_n22   = o_n22_q;
  assign out_n23   = o_n23_q;
  assign bist_busy = (state_q == S_DRAIN) || (state_q == S_RUN) || (state_q == S_FLUSH);
  assign bist_done = (state_q == S_DONE);
  assign bist_sig  = sig_q;

endmodule

// File: tb/tb_c17_pipe_bist.sv
// Directed bench for c17_pipe_bist: a LANES=1 and a LANES=4 instance share
// clock, reset and handshake controls so their timing stays in lockstep.
module tb_c17_pipe_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready, bist_start;
  logic [4:0] pat1;  // {N1,N2,N3,N6,N7} for the single-lane instance
  logic [3:0] n1_4, n2_4, n3_4, n6_4, n7_4;

  logic        in_ready1, out_valid1, o22_1, o23_1, busy1, done1;
  logic [15:0] sig1;
  logic        in_ready4, out_valid4, busy4, done4;
  logic [3:0]  o22_4, o23_4;
  logic [15:0] sig4;

  c17_pipe_bist #(.LANES(1), .PIPE(2)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_n1(pat1[4]), .in_n2(pat1[3]), .in_n3(pat1[2]), .in_n6(pat1[1]), .in_n7(pat1[0]),
    .out_valid(out_valid1), .out_ready(out_ready), .out_n22(o22_1), .out_n23(o23_1),
    .bist_start(bist_start), .bist_busy(busy1), .bist_done(done1), .bist_sig(sig1)
  );

  c17_pipe_bist #(.LANES(4), .PIPE(2)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_n1(n1_4), .in_n2(n2_4), .in_n3(n3_4), .in_n6(n6_4), .in_n7(n7_4),
    .out_valid(out_valid4), .out_ready(out_ready), .out_n22(o22_4), .out_n23(o23_4),
    .bist_start(bist_start), .bist_busy(busy4), .bist_done(done4), .bist_sig(sig4)
  );

  typedef struct {
    logic [4:0] v;
    logic       e22;
    logic       e23;
  } vec_t;
  vec_t tbl[10];

  int checks = 0;
  int errors = 0;

  logic [1:0] expq[$];
  int   n_out, first_take, last_take, ready_low, busy_cnt, done_rises, cyc_n;
  bit   done_prev, last_acc, hold_pend;
  logic [1:0] hold_val;
  logic [15:0] sig_first, exp_sig1, exp_sig4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // {n23,n22} straight from the netlist equations
  function automatic logic [1:0] c17(input logic [4:0] v);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    n1 = v[4]; n2 = v[3]; n3 = v[2]; n6 = v[1]; n7 = v[0];
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic logic [15:0] misr_model(input int lanes);
    logic [15:0] s, d;
    logic [4:0]  q;
    logic [1:0]  r;
    s = '0;
    for (int p = 0; p < 32; p++) begin
      d = '0;
      for (int i = 0; i < lanes; i++) begin
        q = 5'((p + i) % 32);
        r = c17(q);
        d[i]         = r[0];
        d[lanes + i] = r[1];
      end
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    end
    return s;
  endfunction

  // One clock cycle: inputs already driven at the negedge; sample just after.
  task automatic cyc();
    #1;
    if (hold_pend) begin
      chk("hold_stable", {30'b0, o23_1, o22_1}, {30'b0, hold_val});
      hold_pend = 0;
    end
    if (out_valid1 && !out_ready) begin
      hold_pend = 1;
      hold_val  = {o23_1, o22_1};
    end
    if (out_valid1 && out_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_output actual=%0h expected=none", {o23_1, o22_1});
      end else begin
        chk("out_data", {30'b0, o23_1, o22_1}, {30'b0, expq.pop_front()});
        n_out++;
        if (n_out == 1) first_take = cyc_n;
        last_take = cyc_n;
      end
    end
    last_acc = in_valid && in_ready1;
    if (last_acc) expq.push_back(c17(pat1));
    if (in_valid && !in_ready1) ready_low++;
    if (busy1) busy_cnt++;
    if (done1 && !done_prev) done_rises++;
    done_prev = done1;
    @(posedge clk);
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic clr_stats();
    n_out = 0; first_take = 0; last_take = 0; ready_low = 0;
    busy_cnt = 0; done_rises = 0; hold_pend = 0;
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while (!done1 && c < 400) begin
      cyc();
      c++;
    end
    if (!done1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=not_done expected=done", name);
    end
  endtask

  task automatic start_pulse();
    bist_start = 1'b1;
    cyc();
    bist_start = 1'b0;
  endtask

  initial begin
    tbl[0] = '{5'b10110, 1'b1, 1'b0};
    tbl[1] = '{5'b11001, 1'b1, 1'b1};
    tbl[2] = '{5'b00000, 1'b0, 1'b0};
    tbl[3] = '{5'b11111, 1'b1, 1'b0};
    tbl[4] = '{5'b01000, 1'b1, 1'b1};
    tbl[5] = '{5'b00111, 1'b0, 1'b0};
    tbl[6] = '{5'b10101, 1'b1, 1'b1};
    tbl[7] = '{5'b00001, 1'b0, 1'b1};
    tbl[8] = '{5'b01100, 1'b1, 1'b1};
    tbl[9] = '{5'b10010, 1'b0, 1'b0};
    exp_sig1 = misr_model(1);
    exp_sig4 = misr_model(4);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; bist_start = 1'b0; pat1 = '0;
    n1_4 = '0; n2_4 = '0; n3_4 = '0; n6_4 = '0; n7_4 = '0;
    cyc_n = 0; done_prev = 0;
    clr_stats();
    @(posedge clk); @(posedge clk); @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready1, 0);
    chk("rst_out_valid", out_valid1, 0);
    chk("rst_out_data", {o23_1, o22_1}, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sig", sig1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single beats from the hand-computed table, checking the 2-cycle latency.
    for (int k = 0; k < 10; k++) begin
      pat1 = tbl[k].v;
      in_valid = 1'b1;
      #1 chk("tbl_in_ready", in_ready1, 1);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      #1 chk("tbl_lat1_valid", out_valid1, 0);
      @(posedge clk); @(negedge clk);
      #1;
      chk("tbl_lat2_valid", out_valid1, 1);
      chk("tbl_n22", o22_1, tbl[k].e22);
      chk("tbl_n23", o23_1, tbl[k].e23);
      @(posedge clk); @(negedge clk);
    end

    // 32 back-to-back beats with the consumer always ready.
    clr_stats();
    out_ready = 1'b1;
    begin
      int k;
      k = 0;
      for (int c = 0; c < 100 && n_out < 32; c++) begin
        in_valid = (k < 32);
        pat1 = 5'(k);
        cyc();
        if (last_acc) k++;
      end
    end
    in_valid = 1'b0;
    chk("s1_count", n_out, 32);
    chk("s1_ready_low", ready_low, 0);
    chk("s1_span", last_take - first_take, 31);
    chk("s1_q_empty", expq.size(), 0);

    // Same again under a 1,0,0,1 ready pattern.
    clr_stats();
    begin
      int k;
      k = 0;
      for (int c = 0; c < 300 && n_out < 32; c++) begin
        out_ready = (c % 4 == 0) || (c % 4 == 3);
        in_valid = (k < 32);
        pat1 = 5'(k * 7 + 3);
        cyc();
        if (last_acc) k++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("s2_count", n_out, 32);
    chk("s2_ready_dropped", (ready_low > 0), 1);
    chk("s2_q_empty", expq.size(), 0);
    @(negedge clk);
    hold_pend = 0;

    // Four lanes, each with its own pattern (table rows 0..3).
    for (int i = 0; i < 4; i++) begin
      n1_4[i] = tbl[i].v[4]; n2_4[i] = tbl[i].v[3]; n3_4[i] = tbl[i].v[2];
      n6_4[i] = tbl[i].v[1]; n7_4[i] = tbl[i].v[0];
    end
    pat1 = tbl[0].v;
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    #1;
    chk("l4_valid", out_valid4, 1);
    chk("l4_n22", o22_4, 4'b1011);
    chk("l4_n23", o23_4, 4'b0010);
    @(posedge clk); @(negedge clk);
    n1_4 = '0; n2_4 = '0; n3_4 = '0; n6_4 = '0; n7_4 = '0;

    // Self-test with two user beats stuck behind a stalled consumer.
    clr_stats();
    out_ready = 1'b0;
    in_valid = 1'b1;
    pat1 = tbl[0].v;
    cyc();
    pat1 = tbl[7].v;
    cyc();
    in_valid = 1'b0;
    start_pulse();
    cyc();
    cyc();
    out_ready = 1'b1;
    wait_done("bist1");
    chk("bist1_user_beats", n_out, 2);
    chk("bist1_q_empty", expq.size(), 0);
    chk("bist1_busy_cycles", busy_cnt, 40);
    chk("bist1_sig_l1", sig1, exp_sig1);
    chk("bist1_sig_l4", sig4, exp_sig4);
    chk("bist1_sig_differ", (sig1 != sig4), 1);
    chk("bist1_busy_low", busy1, 0);
    sig_first = sig1;
    cyc();
    cyc();
    chk("done_sig_held", sig1, sig_first);
    chk("done_in_ready", in_ready1, 1);

    // Second run must reproduce the signature.
    clr_stats();
    start_pulse();
    #1;
    chk("bist2_sig_cleared", sig1, 0);
    chk("bist2_done_cleared", done1, 0);
    chk("bist2_in_ready", in_ready1, 0);
    wait_done("bist2");
    chk("bist2_busy_cycles", busy_cnt, 36);
    chk("bist2_sig_repeat", sig1, sig_first);

    // Reset on RUN cycle 10, then a clean run.
    clr_stats();
    start_pulse();
    for (int c = 0; c < 11; c++) cyc();
    rst = 1'b1;
    cyc();
    #1;
    chk("mrst_in_ready", in_ready1, 0);
    chk("mrst_out_valid", out_valid1, 0);
    chk("mrst_out_data", {o23_1, o22_1}, 0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_done", done1, 0);
    chk("mrst_sig", sig1, 0);
    chk("mrst_sig_l4", sig4, 0);
    rst = 1'b0;
    #1 chk("mrst_idle_ready", in_ready1, 1);
    @(negedge clk);
    clr_stats();
    start_pulse();
    wait_done("bist3");
    for (int c = 0; c < 5; c++) cyc();
    chk("bist3_busy_cycles", busy_cnt, 36);
    chk("bist3_done_rises", done_rises, 1);
    chk("bist3_sig", sig1, exp_sig1);

    // A second start while running is ignored.
    clr_stats();
    start_pulse();
    for (int c = 0; c < 6; c++) cyc();
    start_pulse();
    wait_done("bist4");
    for (int c = 0; c < 5; c++) cyc();
    chk("bist4_done_rises", done_rises, 1);
    chk("bist4_busy_cycles", busy_cnt, 36);
    chk("bist4_sig", sig1, exp_sig1);
    chk("bist4_sig_l4", sig4, exp_sig4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
